// File: rtl/j1_pkg.sv
// Shared definitions for the J1 interrupt controller: register map, CTRL bits
// and controller state encodings.
package j1_pkg;

  localparam int NSRC_MAX = 8;

  // Register offsets, selected by io_addr[2:1].
  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_VEC  = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_EOI_BIT = 1;
  localparam int VEC_ISV_BIT  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } irq_state_e;

endpackage

// File: rtl/j1_irq_ctrl_if.sv
// CPU I/O bus as seen by a memory-mapped peripheral on the J1.
interface j1_irq_ctrl_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] rd_data;
  logic        sel;

  modport master (
    output io_rd, io_wr, io_addr, io_dout,
    input  rd_data, sel
  );

  modport slave (
    input  io_rd, io_wr, io_addr, io_dout,
    output rd_data, sel
  );
endinterface

// File: rtl/j1_prio_enc.sv
// Fixed-priority encoder: the lowest set bit wins; valid flags a non-empty vector.
module j1_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [2:0]   idx,
  output logic         valid
);

  always_comb begin
    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    idx = '0;
    // Scan downward so the last (lowest) hit overrides higher ones.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/j1_irq_ctrl.sv
// Interrupt controller for the J1 core: edge-triggered pending bits, mask,
// single-level (non-nested) service with explicit EOI.
import j1_pkg::*;

module j1_irq_ctrl #(
  parameter int          NSRC = 4,
  parameter logic [15:0] BASE = 16'h6000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq_src,
  j1_irq_ctrl_if.slave    bus,
  output logic            int_req,
  input  logic            int_ack
);

  logic [NSRC-1:0] pend, pend_d, mask, src_prev, rise, cand, w1c_clr, ack_clr;
  logic            en;
  logic [2:0]      vec_idx;
  logic            vec_isv;
  irq_state_e      state, state_d;
  logic [2:0]      top_idx;
  logic            top_valid;
  logic [1:0]      reg_off;
  logic            wr_pend, wr_mask, wr_ctrl, eoi;
  logic            take_ack, take_eoi;
  logic [15:0]     rd_mux;
  logic            unused_bits;

  // Address bit 0 and write-data bits beyond the source count carry no meaning here.
  assign unused_bits = ^{bus.io_rd, bus.io_addr[0], bus.io_dout[15:NSRC]};

  assign bus.sel = (bus.io_addr[15:3] == BASE[15:3]);
  assign reg_off = bus.io_addr[2:1];
  assign wr_pend = bus.io_wr && bus.sel && (reg_off == OFF_PEND);
  assign wr_mask = bus.io_wr && bus.sel && (reg_off == OFF_MASK);
  assign wr_ctrl = bus.io_wr && bus.sel && (reg_off == OFF_CTRL);
  assign eoi     = wr_ctrl && bus.io_dout[CTRL_EOI_BIT];

  assign rise = irq_src & ~src_prev;
  assign cand = pend & mask;

  j1_prio_enc #(.N(NSRC)) u_prio (
    .vec   (cand),
    .idx   (top_idx),
    .valid (top_valid)
  );

  always_comb begin
    state_d  = state;
    take_ack = 1'b0;
    take_eoi = 1'b0;
    unique case (state)
      ST_IDLE: if (en && top_valid) state_d = ST_REQ;
      ST_REQ: begin
        // Withdrawal takes precedence: an ack for a vanished candidate is dropped.
        if (!en || !top_valid) begin
          state_d = ST_IDLE;
        end else if (int_ack) begin
          state_d  = ST_SERV;
          take_ack = 1'b1;
        end
      end
      ST_SERV: begin
        if (eoi) begin
          state_d  = ST_IDLE;
          take_eoi = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = take_ack && (top_idx == 3'(i));
    end
    w1c_clr = wr_pend ? bus.io_dout[NSRC-1:0] : '0;
    // A new edge in the same cycle as a clear keeps the bit pending.
    pend_d  = (pend & ~(w1c_clr | ack_clr)) | rise;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_prev <= '0;
      pend     <= '0;
      mask     <= '0;
      en       <= 1'b0;
      vec_idx  <= '0;
      vec_isv  <= 1'b0;
      state    <= ST_IDLE;
      int_req  <= 1'b0;
    end else begin
      src_prev <= irq_src;
      pend     <= pend_d;
      if (wr_mask) mask <= bus.io_dout[NSRC-1:0];
      if (wr_ctrl) en   <= bus.io_dout[CTRL_EN_BIT];
      state   <= state_d;
      int_req <= (state_d == ST_REQ);
      if (take_ack) begin
        vec_idx <= top_idx;
        vec_isv <= 1'b1;
      end else if (take_eoi) begin
        vec_isv <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.sel) begin
      unique case (reg_off)
        OFF_PEND: rd_mux[NSRC-1:0] = pend;
        OFF_MASK: rd_mux[NSRC-1:0] = mask;
        OFF_VEC: begin
          rd_mux[2:0]         = vec_idx;
          rd_mux[VEC_ISV_BIT] = vec_isv;
        end
        OFF_CTRL: rd_mux[CTRL_EN_BIT] = en;
        default:  rd_mux = '0;
      endcase
    end
  end

  assign bus.rd_data = rd_mux;

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// Directed bench for j1_irq_ctrl with a scoreboard queue of expected values.
module tb_j1_irq_ctrl;
  import j1_pkg::*;

  localparam logic [15:0] BASE   = 16'h6000;
  localparam logic [15:0] A_PEND = BASE + 16'd0;
  localparam logic [15:0] A_MASK = BASE + 16'd2;
  localparam logic [15:0] A_VEC  = BASE + 16'd4;
  localparam logic [15:0] A_CTRL = BASE + 16'd6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] irq_src = '0;
  logic       int_ack = 1'b0;
  logic       int_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;
  exp_t sb[$];

  j1_irq_ctrl_if bus ();

  j1_irq_ctrl #(.NSRC(4), .BASE(BASE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_src (irq_src),
    .bus     (bus),
    .int_req (int_req),
    .int_ack (int_ack)
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [15:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected an entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.value)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.value);
      end
  endtask

  task automatic rd_check(input logic [15:0] addr, input string tag, input logic [15:0] v);
    expect_val(tag, v);
    bus.io_addr = addr;
    bus.io_rd   = 1'b1;
    #1;
    check(bus.rd_data);
    bus.io_rd   = 1'b0;
    bus.io_addr = 16'h0000;
  endtask

  task automatic sel_check(input logic [15:0] addr, input string tag, input logic v);
    expect_val(tag, {15'd0, v});
    bus.io_addr = addr;
    #1;
    check({15'd0, bus.sel});
    bus.io_addr = 16'h0000;
  endtask

  task automatic irq_check(input string tag, input logic v);
    expect_val(tag, {15'd0, v});
    check({15'd0, int_req});
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
    bus.io_addr = addr;
    bus.io_dout = data;
    bus.io_wr   = 1'b1;
    tick();
    bus.io_wr   = 1'b0;
    bus.io_addr = 16'h0000;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    bus.io_rd   = 1'b0;
    bus.io_wr   = 1'b0;
    bus.io_addr = 16'h0000;
    bus.io_dout = 16'h0000;
    #120;

    // Reset state and decode
    rd_check(A_PEND, "rst_pend", 16'h0000);
    rd_check(A_VEC,  "rst_vec",  16'h0000);
    irq_check("rst_int_req", 1'b0);
    rst_n = 1'b1;
    tick();
    rd_check(A_MASK, "post_rst_mask", 16'h0000);
    rd_check(A_CTRL, "post_rst_ctrl", 16'h0000);
    sel_check(BASE + 16'd7, "sel_top", 1'b1);
    sel_check(BASE + 16'd8, "sel_above", 1'b0);
    sel_check(BASE - 16'd1, "sel_below", 1'b0);

    // Single source service
    io_write(A_MASK, 16'hFFFF);
    io_write(A_CTRL, 16'h0001);
    rd_check(A_MASK, "mask_trunc", 16'h000F);
    rd_check(BASE + 16'd3, "addr0_ignored", 16'h000F);
    rd_check(BASE + 16'd8, "unsel_zero", 16'h0000);
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    irq_check("src2_not_yet", 1'b0);
    tick();
    irq_check("src2_req", 1'b1);
    ack_pulse();
    rd_check(A_VEC,  "src2_vec",  16'h8002);
    rd_check(A_PEND, "src2_pend", 16'h0000);
    irq_check("src2_req_drop", 1'b0);
    ack_pulse();
    rd_check(A_VEC, "serv_ack_ignored", 16'h8002);
    io_write(A_CTRL, 16'h0003);
    rd_check(A_VEC, "eoi_vec", 16'h0002);
    irq_check("eoi_idle", 1'b0);

    // Simultaneous sources, priority and re-request after EOI
    irq_src = 4'b1010;
    tick();
    irq_src = 4'b0000;
    tick();
    irq_check("dual_req", 1'b1);
    ack_pulse();
    rd_check(A_VEC,  "dual_vec1",  16'h8001);
    rd_check(A_PEND, "dual_pend1", 16'h0008);
    irq_check("dual_serv_no_nest", 1'b0);
    io_write(A_CTRL, 16'h0003);
    irq_check("reassert_wait", 1'b0);
    tick();
    irq_check("reassert", 1'b1);
    ack_pulse();
    rd_check(A_VEC,  "dual_vec3",  16'h8003);
    rd_check(A_PEND, "dual_pend3", 16'h0000);
    io_write(A_CTRL, 16'h0003);

    // Masked source
    io_write(A_MASK, 16'h000E);
    irq_src = 4'b0001;
    tick();
    irq_src = 4'b0000;
    tick();
    tick();
    rd_check(A_PEND, "masked_pend", 16'h0001);
    irq_check("masked_no_req", 1'b0);
    io_write(A_MASK, 16'h000F);
    tick();
    irq_check("unmask_req", 1'b1);

    // Withdrawal in REQ via W1C, late ack ignored
    io_write(A_PEND, 16'h000F);
    tick();
    irq_check("withdraw_drop", 1'b0);
    rd_check(A_PEND, "withdraw_pend", 16'h0000);
    ack_pulse();
    rd_check(A_VEC, "late_ack_vec", 16'h0003);
    tick();
    irq_check("late_ack_no_req", 1'b0);

    // Set beats W1C in the same cycle
    io_write(A_MASK, 16'h0000);
    irq_src = 4'b0010;
    tick();
    irq_src = 4'b0000;
    tick();
    rd_check(A_PEND, "w1c_setup", 16'h0002);
    irq_src = 4'b0010;
    io_write(A_PEND, 16'h0002);
    rd_check(A_PEND, "set_wins", 16'h0002);
    io_write(A_PEND, 16'h0002);
    rd_check(A_PEND, "w1c_level_held", 16'h0000);
    irq_src = 4'b0000;
    tick();

    // Global enable gating, EN+EOI together in IDLE
    io_write(A_CTRL, 16'h0000);
    io_write(A_MASK, 16'h000F);
    irq_src = 4'b0001;
    tick();
    irq_src = 4'b0000;
    tick();
    tick();
    irq_check("disabled_no_req", 1'b0);
    io_write(A_CTRL, 16'h0003);
    tick();
    irq_check("enabled_req", 1'b1);
    rd_check(A_CTRL, "ctrl_eoi_reads0", 16'h0001);
    ack_pulse();
    rd_check(A_VEC, "src0_vec", 16'h8000);

    // Asynchronous reset mid-service, source held high through reset
    irq_src = 4'b1000;
    tick();
    irq_check("serv_blocks_new", 1'b0);
    #10;
    rst_n = 1'b0;
    #1;
    irq_check("async_rst_req", 1'b0);
    rd_check(A_PEND, "async_rst_pend", 16'h0000);
    rd_check(A_MASK, "async_rst_mask", 16'h0000);
    rd_check(A_VEC,  "async_rst_vec",  16'h0000);
    rd_check(A_CTRL, "async_rst_ctrl", 16'h0000);
    #10;
    rst_n = 1'b1;
    tick();
    rd_check(A_PEND, "held_src_pend", 16'h0008);
    irq_check("held_src_masked", 1'b0);
    irq_src = 4'b0000;
    tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
